wb_trace_monitor: RTL and testbench
===================================

Name: wb_trace_monitor

Overview:
- Parametrised on-chip trace capture for processor writeback buses, fed by the integer/FP writeback data and FP exception flags.
- Stores a circular window of samples around a programmable trigger with a configurable pre-trigger depth, then exposes the buffer through a synchronous read port for debug readout.
- Generalises fixed three-probe monitoring to NUM_CH channels, with per-channel valid qualification, value/flag triggering and sticky flag accumulation.

Parameters:
- NUM_CH, 3, number of monitored data channels.
- DATA_W, 32, width of each channel.
- FLAG_W, 5, FP exception flag width (NV,DZ,OF,UF,NX).
- DEPTH, 64, buffer entries; power of two, >= 4.
- PRE_TRIG, 16, samples required before the trigger; must be < DEPTH.
- AW = $clog2(DEPTH), derived.
- SW = NUM_CH*DATA_W + FLAG_W + NUM_CH, derived sample width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ch_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- ch_valid  in  NUM_CH  per-channel sample qualifier.
- fp_flags  in  FLAG_W  FP exception flags this cycle.
- arm  in  1  single-cycle start/restart request.
- trig_mask  in  NUM_CH  channels enabled for the value compare.
- trig_value  in  DATA_W  compare value.
- trig_flag_mask  in  FLAG_W  flags that trigger when set.
- rd_addr  in  AW  readback address.
- rd_data  out  SW  {ch_valid, fp_flags, ch_data} stored at rd_addr.
- state  out  2  0=IDLE 1=ARMED 2=POST 3=DONE.
- done  out  1  high in DONE.
- trig_index  out  AW  buffer address of the trigger sample.
- start_addr  out  AW  address of the oldest sample (final wr_ptr).
- sticky_flags  out  FLAG_W  OR of fp_flags since the last arm.

Behaviour:
- Reset (async): state=IDLE; wr_ptr, pre_cnt, post_cnt, trig_index, start_addr, sticky_flags and rd_data all 0; done=0. Buffer contents are undefined, not cleared.
- Sample = {ch_valid, fp_flags, ch_data}, taken every cycle in ARMED and POST and written at wr_ptr. wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
- IDLE or DONE, arm=1: next cycle enter ARMED; wr_ptr=0, pre_cnt=0, sticky_flags=0, done=0. The arm cycle itself is not sampled.
- arm is ignored in ARMED and POST.
- ARMED:
  - pre_cnt counts written samples and saturates at PRE_TRIG.
  - trig_hit = OR over i of (trig_mask[i] & ch_valid[i] & ch_data_i==trig_value), OR |(fp_flags & trig_flag_mask).
  - trig_hit is honoured only when pre_cnt==PRE_TRIG at the start of that cycle; earlier hits are ignored.
  - On an honoured hit: the sample is written, trig_index<=wr_ptr, post_cnt<=DEPTH-PRE_TRIG-1, next state POST.
  - If DEPTH-PRE_TRIG-1==0, go directly to DONE with start_addr<=wr_ptr+1.
- POST:
  - Each cycle: write the sample, then decrement post_cnt.
  - The write made when post_cnt==1 is the last; next cycle state=DONE, done=1, start_addr=final wr_ptr.
  - trig_hit is ignored in POST.
- DONE: no writes. The buffer holds exactly DEPTH samples, oldest at start_addr.
- sticky_flags |= fp_flags on every sampled cycle (ARMED, POST); holds in IDLE and DONE.
- Readback: rd_data <= mem[rd_addr] every cycle (1-cycle latency), in any state. A read and write to the same address in one cycle returns the old contents.
- Reset asserted mid-capture: immediate return to IDLE, done=0; capture is abandoned.

Test Plan:
- Reset: assert reset mid-cycle with no clk -> state=0, done=0, sticky_flags=0, trig_index=0, rd_data=0 immediately.
- Value trigger (DEPTH=16, PRE_TRIG=4): arm; ch1 = 0xDEADBEEF, valid, trig_mask=3'b010 on the 11th sampled cycle -> trig_index=10; 11 POST writes; done rises on the 12th cycle after the trigger; start_addr=6. Reading addr 10 returns ch1=0xDEADBEEF.
- Early hit ignored: trigger value on sample 2 (pre_cnt<4) -> state stays ARMED; a second hit on sample 6 -> trig_index=5.
- Flag trigger and masking:
  - trig_mask=0, trig_flag_mask=5'b00001, fp_flags=5'b00001 after pre-fill -> POST entered.
  - The same ch value with ch_valid=0 does not trigger.
  - sticky_flags=5'b00001 after the hit.
- Reset mid-POST: reset 3 cycles after the trigger -> IDLE, done=0. A subsequent arm restarts with wr_ptr=0 and sticky_flags=0.
- Wrap and re-arm: hold ARMED for 40 cycles (DEPTH=16) before the trigger -> pointer wraps; trig_index=40 mod 16=8. Arm in DONE -> ARMED; arm pulsed during POST has no effect.

Source files
------------

// File: rtl/wb_trace_monitor.sv
// Trace capture for writeback buses. Samples the channels into a circular buffer
// around a value or flag trigger, then serves the buffer through a registered read port.
module wb_trace_monitor #(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 32,
    parameter int FLAG_W   = 5,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = NUM_CH*DATA_W + FLAG_W + NUM_CH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [FLAG_W-1:0]        fp_flags,
    input  logic                     arm,
    input  logic [NUM_CH-1:0]        trig_mask,
    input  logic [DATA_W-1:0]        trig_value,
    input  logic [FLAG_W-1:0]        trig_flag_mask,
    input  logic [AW-1:0]            rd_addr,
    output logic [SW-1:0]            rd_data,
    output logic [1:0]               state,
    output logic                     done,
    output logic [AW-1:0]            trig_index,
    output logic [AW-1:0]            start_addr,
    output logic [FLAG_W-1:0]        sticky_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
    localparam logic [AW-1:0] PRE_TRIG_C = AW'(PRE_TRIG);
    localparam logic [AW-1:0] POST_LEN_C = AW'(POST_LEN);
    localparam logic [AW-1:0] ONE_C      = AW'(1);

    state_t            state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     pre_cnt_reg;
    logic [AW-1:0]     post_cnt_reg;
    logic [AW-1:0]     trig_index_reg;
    logic [AW-1:0]     start_addr_reg;
    logic [FLAG_W-1:0] sticky_reg;
    logic              done_reg;
    logic [SW-1:0]     rd_data_reg;

    logic [SW-1:0]     mem [DEPTH];
    logic [NUM_CH-1:0] ch_match;
    logic              trig_hit;
    logic              capture;
    logic [SW-1:0]     sample;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_match
            assign ch_match[gi] = trig_mask[gi] & ch_valid[gi] &
                                  (ch_data[gi*DATA_W +: DATA_W] == trig_value);
        end
    endgenerate

    assign trig_hit = (|ch_match) | (|(fp_flags & trig_flag_mask));
    assign capture  = (state_reg == ARMED) || (state_reg == POST);
    assign sample   = {ch_valid, fp_flags, ch_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            pre_cnt_reg    <= '0;
            post_cnt_reg   <= '0;
            trig_index_reg <= '0;
            start_addr_reg <= '0;
            sticky_reg     <= '0;
            done_reg       <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_C;
                sticky_reg <= sticky_reg | fp_flags;
            end
            case (state_reg)
                IDLE, DONE: begin
                    if (arm) begin
                        state_reg   <= ARMED;
                        wr_ptr_reg  <= '0;
                        pre_cnt_reg <= '0;
                        sticky_reg  <= '0;
                        done_reg    <= 1'b0;
                    end
                end
                ARMED: begin
                    // Hits only count once the pre-trigger window is full.
                    if (pre_cnt_reg == PRE_TRIG_C) begin
                        if (trig_hit) begin
                            trig_index_reg <= wr_ptr_reg;
                            if (POST_LEN == 0) begin
                                state_reg      <= DONE;
                                done_reg       <= 1'b1;
                                start_addr_reg <= wr_ptr_reg + ONE_C;
                            end else begin
                                post_cnt_reg <= POST_LEN_C;
                                state_reg    <= POST;
                            end
                        end
                    end else begin
                        pre_cnt_reg <= pre_cnt_reg + ONE_C;
                    end
                end
                POST: begin
                    post_cnt_reg <= post_cnt_reg - ONE_C;
                    if (post_cnt_reg == ONE_C) begin
                        state_reg      <= DONE;
                        done_reg       <= 1'b1;
                        start_addr_reg <= wr_ptr_reg + ONE_C;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Buffer RAM: no reset so it maps onto block RAM; read returns old data on collision.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr_reg] <= sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data      = rd_data_reg;
    assign state        = state_reg;
    assign done         = done_reg;
    assign trig_index   = trig_index_reg;
    assign start_addr   = start_addr_reg;
    assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Randomized bench for wb_trace_monitor, checked against a sample-count based
// reference model of the capture window.
module tb_wb_trace_monitor;

    localparam int NUM_CH   = 3;
    localparam int DATA_W   = 32;
    localparam int FLAG_W   = 5;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int AW       = $clog2(DEPTH);
    localparam int SW       = NUM_CH*DATA_W + FLAG_W + NUM_CH;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]        ch_valid = '0;
    logic [FLAG_W-1:0]        fp_flags = '0;
    logic                     arm = 1'b0;
    logic [NUM_CH-1:0]        trig_mask = '0;
    logic [DATA_W-1:0]        trig_value = '0;
    logic [FLAG_W-1:0]        trig_flag_mask = '0;
    logic [AW-1:0]            rd_addr = '0;
    logic [SW-1:0]            rd_data;
    logic [1:0]               state;
    logic                     done;
    logic [AW-1:0]            trig_index;
    logic [AW-1:0]            start_addr;
    logic [FLAG_W-1:0]        sticky_flags;

    wb_trace_monitor #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FLAG_W(FLAG_W),
        .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid),
        .fp_flags(fp_flags), .arm(arm), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_flag_mask(trig_flag_mask),
        .rd_addr(rd_addr), .rd_data(rd_data), .state(state), .done(done),
        .trig_index(trig_index), .start_addr(start_addr),
        .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_lat;

    // Model: phase 0 idle, 1 armed, 2 post, 3 done; derived from sample counts.
    int                m_phase = 0;
    int                m_count = 0;
    int                m_trig  = -1;
    logic [FLAG_W-1:0] m_sticky = '0;
    logic [AW-1:0]     m_trig_index = '0;
    logic [AW-1:0]     m_start = '0;
    logic [SW-1:0]     m_mem [DEPTH];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic hit_now();
        logic h;
        h = |(fp_flags & trig_flag_mask);
        for (int c = 0; c < NUM_CH; c++)
            if (trig_mask[c] && ch_valid[c] && ch_data[c*DATA_W +: DATA_W] == trig_value)
                h = 1'b1;
        return h;
    endfunction

    task automatic model_step();
        if (m_phase == 0 || m_phase == 3) begin
            if (arm) begin
                m_phase = 1; m_count = 0; m_trig = -1; m_sticky = '0;
            end
        end else begin
            m_mem[m_count % DEPTH] = {ch_valid, fp_flags, ch_data};
            m_sticky = m_sticky | fp_flags;
            if (m_trig < 0 && m_count >= PRE_TRIG && hit_now()) begin
                m_trig = m_count;
                m_trig_index = AW'(m_count % DEPTH);
            end
            m_count++;
            if (m_trig >= 0)
                m_phase = (m_count == m_trig + DEPTH - PRE_TRIG) ? 3 : 2;
            if (m_phase == 3)
                m_start = AW'(m_count % DEPTH);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk); #1;
        check_val("state", 128'(state), 128'(m_phase));
        check_val("done", 128'(done), 128'(m_phase == 3));
        check_val("sticky", 128'(sticky_flags), 128'(m_sticky));
        check_val("trig_index", 128'(trig_index), 128'(m_trig_index));
        check_val("start_addr", 128'(start_addr), 128'(m_start));
    endtask

    task automatic rand_sample(input bit inject);
        int c;
        for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = $urandom;
        ch_valid = NUM_CH'($urandom);
        if (inject) begin
            fp_flags = FLAG_W'($urandom);
            c = $urandom_range(0, NUM_CH-1);
            ch_data[c*DATA_W +: DATA_W] = trig_value;
            ch_valid[c] = 1'b1;
        end else begin
            fp_flags = FLAG_W'($urandom) & ~trig_flag_mask;
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1; rand_sample(0); cycle(); arm = 1'b0;
    endtask

    task automatic run_to_done(input int max_cycles, input int inj_div, output int n);
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            rand_sample(inj_div > 0 && $urandom_range(0, inj_div-1) == 0);
            cycle();
            n++;
        end
        check_val("done_reached", 128'(done), 128'(1));
    endtask

    task automatic readback();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            @(posedge clk); #1;
            check_val("rd_data", 128'(rd_data), 128'(m_mem[a]));
        end
    endtask

    task automatic mid_reset();
        #3 reset = 1'b1;
        #1;
        m_phase = 0; m_sticky = '0; m_trig_index = '0; m_start = '0;
        check_val("rst_state", 128'(state), 128'(0));
        check_val("rst_done", 128'(done), 128'(0));
        check_val("rst_sticky", 128'(sticky_flags), 128'(0));
        check_val("rst_trig_index", 128'(trig_index), 128'(0));
        check_val("rst_start", 128'(start_addr), 128'(0));
        check_val("rst_rd_data", 128'(rd_data), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        reset = 1'b0;
        cycle();
        mid_reset();

        // Value trigger on channel 1 at sample 10.
        trig_mask = 3'b010; trig_value = 32'hDEADBEEF; trig_flag_mask = '0;
        arm_pulse();
        for (int i = 0; i < 10; i++) begin rand_sample(0); cycle(); end
        rand_sample(0);
        ch_data[DATA_W +: DATA_W] = 32'hDEADBEEF; ch_valid[1] = 1'b1;
        cycle();
        check_val("vt_state_post", 128'(state), 128'(2));
        check_val("vt_trig_index", 128'(trig_index), 128'(10));
        run_to_done(40, 0, n_lat);
        check_val("vt_done_lat", 128'(n_lat), 128'(DEPTH - PRE_TRIG - 1));
        check_val("vt_start", 128'(start_addr), 128'(6));
        readback();
        rd_addr = AW'(10);
        @(posedge clk); #1;
        check_val("vt_rd10_ch1", 128'(rd_data[DATA_W +: DATA_W]), 128'(32'hDEADBEEF));

        // Early hit during pre-fill is ignored; later hit at sample 5 is taken.
        trig_mask = 3'b001; trig_value = $urandom;
        arm_pulse();
        for (int i = 0; i < 6; i++) begin
            rand_sample(0);
            if (i == 2 || i == 5) begin
                ch_data[DATA_W-1:0] = trig_value; ch_valid[0] = 1'b1;
            end
            cycle();
            if (i == 2) check_val("eh_still_armed", 128'(state), 128'(1));
        end
        check_val("eh_trig_index", 128'(trig_index), 128'(5));
        run_to_done(40, 0, n_lat);
        readback();

        // Invalid channel match ignored, then flag trigger.
        trig_mask = 3'b010; trig_value = $urandom; trig_flag_mask = 5'b00001;
        arm_pulse();
        for (int i = 0; i < PRE_TRIG; i++) begin rand_sample(0); fp_flags = '0; cycle(); end
        rand_sample(0); fp_flags = '0;
        ch_data[DATA_W +: DATA_W] = trig_value; ch_valid[1] = 1'b0;
        cycle();
        check_val("ft_invalid_no_trig", 128'(state), 128'(1));
        trig_mask = '0;
        rand_sample(0); fp_flags = 5'b00001;
        cycle();
        check_val("ft_post", 128'(state), 128'(2));
        check_val("ft_sticky", 128'(sticky_flags), 128'(5'b00001));
        run_to_done(40, 0, n_lat);
        readback();

        // Reset three cycles into POST, then restart from a clean pointer.
        trig_mask = 3'b001; trig_value = $urandom; trig_flag_mask = '0;
        arm_pulse();
        for (int i = 0; i < PRE_TRIG; i++) begin rand_sample(0); cycle(); end
        rand_sample(1); ch_data[DATA_W-1:0] = trig_value; ch_valid[0] = 1'b1; cycle();
        for (int i = 0; i < 3; i++) begin rand_sample(0); cycle(); end
        mid_reset();
        arm_pulse();
        check_val("rp_armed", 128'(state), 128'(1));
        check_val("rp_sticky_clear", 128'(sticky_flags), 128'(0));
        for (int i = 0; i < PRE_TRIG; i++) begin rand_sample(0); cycle(); end
        rand_sample(0); ch_data[DATA_W-1:0] = trig_value; ch_valid[0] = 1'b1; cycle();
        check_val("rp_trig_index", 128'(trig_index), 128'(PRE_TRIG));
        run_to_done(40, 0, n_lat);
        readback();

        // Long pre-fill wraps the pointer; arm during POST is ignored.
        trig_mask = 3'b100; trig_value = $urandom;
        arm_pulse();
        for (int i = 0; i < 40; i++) begin rand_sample(0); cycle(); end
        rand_sample(0); ch_data[2*DATA_W +: DATA_W] = trig_value; ch_valid[2] = 1'b1; cycle();
        check_val("wr_trig_index", 128'(trig_index), 128'(8));
        rand_sample(0); cycle();
        arm_pulse();
        check_val("wr_arm_in_post", 128'(state), 128'(2));
        run_to_done(40, 0, n_lat);
        readback();
        arm_pulse();
        check_val("wr_rearm_done", 128'(state), 128'(1));

        // Random trigger configurations and hit injection.
        for (int k = 0; k < 6; k++) begin
            trig_mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            trig_value = $urandom;
            trig_flag_mask = ($urandom_range(0, 1) == 0) ? '0 : FLAG_W'($urandom);
            if (m_phase == 0 || m_phase == 3) arm_pulse();
            run_to_done(300, 5, n_lat);
            readback();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
